// File: rtl/eee_img_proc_if.sv
// Bundle of the Avalon-MM slave bus and the Avalon-ST sink/source pixel streams.
// slave: the pixel processor side; master: the CPU/camera/display side.
interface eee_img_proc_if;
  logic        s_chipselect;
  logic        s_read;
  logic        s_write;
  logic [2:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;

  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;

  modport slave (
    input  s_chipselect, s_read, s_write, s_address, s_writedata,
    output s_readdata,
    input  sink_data, sink_valid, sink_sop, sink_eop,
    output sink_ready,
    output source_data, source_valid, source_sop, source_eop,
    input  source_ready
  );

  modport master (
    output s_chipselect, s_read, s_write, s_address, s_writedata,
    input  s_readdata,
    output sink_data, sink_valid, sink_sop, sink_eop,
    input  sink_ready,
    input  source_data, source_valid, source_sop, source_eop,
    output source_ready
  );
endinterface

// File: rtl/eee_img_proc.sv
// Streaming RGB pixel processor: highlights pixels inside a programmable colour box and
// collects per-frame match count and bounding box, exposed over an Avalon-MM slave.
module eee_img_proc #(
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  eee_img_proc_if.slave bus
);

  localparam logic [23:0] LowRst    = 24'hC00000;
  localparam logic [23:0] HighRst   = 24'hFF4040;
  localparam logic [23:0] HiliteRst = 24'h00FF00;
  localparam logic [10:0] XLast     = 11'(IMAGE_W - 1);
  localparam logic [10:0] YLast     = 11'(IMAGE_H - 1);
  localparam logic [10:0] MinRst    = 11'h7FF;

  logic        src_valid_q, src_sop_q, src_eop_q;
  logic [23:0] src_data_q;
  logic [23:0] low_q, high_q, hilite_q;
  logic [10:0] x_q, y_q, x_d, y_d, cur_x, cur_y;
  logic [31:0] acc_count_q, acc_count_d;
  logic [10:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
  logic [10:0] acc_xmin_d, acc_xmax_d, acc_ymin_d, acc_ymax_d;
  logic [31:0] fcount_q, bbmin_q, bbmax_q, frames_q;
  logic [31:0] readdata_q, rdata;
  logic        accept, match;
  logic [23:0] px;

  assign px              = bus.sink_data;
  assign bus.sink_ready  = ~src_valid_q | bus.source_ready;
  assign accept          = bus.sink_valid & bus.sink_ready;
  assign bus.source_valid = src_valid_q;
  assign bus.source_data  = src_data_q;
  assign bus.source_sop   = src_sop_q;
  assign bus.source_eop   = src_eop_q;
  assign bus.s_readdata   = readdata_q;

  assign match = (px[23:16] >= low_q[23:16]) && (px[23:16] <= high_q[23:16]) &&
                 (px[15:8]  >= low_q[15:8])  && (px[15:8]  <= high_q[15:8])  &&
                 (px[7:0]   >= low_q[7:0])   && (px[7:0]   <= high_q[7:0]);

  // An sop pixel sits at (0,0) and starts a fresh set of accumulators that includes itself.
  always_comb begin
    cur_x      = bus.sink_sop ? '0 : x_q;
    cur_y      = bus.sink_sop ? '0 : y_q;
    x_d        = (cur_x == XLast) ? '0 : cur_x + 11'd1;
    y_d        = ((cur_x == XLast) && (cur_y != YLast)) ? cur_y + 11'd1 : cur_y;
    acc_count_d = bus.sink_sop ? '0 : acc_count_q;
    acc_xmin_d  = bus.sink_sop ? MinRst : acc_xmin_q;
    acc_xmax_d  = bus.sink_sop ? '0 : acc_xmax_q;
    acc_ymin_d  = bus.sink_sop ? MinRst : acc_ymin_q;
    acc_ymax_d  = bus.sink_sop ? '0 : acc_ymax_q;
    if (match) begin
      acc_count_d = acc_count_d + 32'd1;
      if (cur_x < acc_xmin_d) acc_xmin_d = cur_x;
      if (cur_x > acc_xmax_d) acc_xmax_d = cur_x;
      if (cur_y < acc_ymin_d) acc_ymin_d = cur_y;
      if (cur_y > acc_ymax_d) acc_ymax_d = cur_y;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (bus.s_address)
      3'd0: rdata = 32'h1234EEE0 | {31'b0, mode};
      3'd1: rdata = {8'b0, low_q};
      3'd2: rdata = {8'b0, high_q};
      3'd3: rdata = {8'b0, hilite_q};
      3'd4: rdata = bbmin_q;
      3'd5: rdata = bbmax_q;
      3'd6: rdata = fcount_q;
      3'd7: rdata = frames_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_data_q  <= '0;
      low_q       <= LowRst;
      high_q      <= HighRst;
      hilite_q    <= HiliteRst;
      x_q         <= '0;
      y_q         <= '0;
      acc_count_q <= '0;
      acc_xmin_q  <= MinRst;
      acc_xmax_q  <= '0;
      acc_ymin_q  <= MinRst;
      acc_ymax_q  <= '0;
      fcount_q    <= '0;
      bbmin_q     <= '0;
      bbmax_q     <= '0;
      frames_q    <= '0;
      readdata_q  <= '0;
    end else begin
      if (accept) begin
        src_valid_q <= 1'b1;
        src_sop_q   <= bus.sink_sop;
        src_eop_q   <= bus.sink_eop;
        src_data_q  <= (mode && match) ? hilite_q : px;
        x_q         <= x_d;
        y_q         <= y_d;
        acc_count_q <= acc_count_d;
        acc_xmin_q  <= acc_xmin_d;
        acc_xmax_q  <= acc_xmax_d;
        acc_ymin_q  <= acc_ymin_d;
        acc_ymax_q  <= acc_ymax_d;
        if (bus.sink_eop) begin
          fcount_q <= acc_count_d;
          bbmin_q  <= {5'b0, acc_ymin_d, 5'b0, acc_xmin_d};
          bbmax_q  <= {5'b0, acc_ymax_d, 5'b0, acc_xmax_d};
          frames_q <= frames_q + 32'd1;
        end
      end else if (bus.source_ready) begin
        src_valid_q <= 1'b0;
      end

      if (bus.s_chipselect && bus.s_write) begin
        case (bus.s_address)
          3'd1:    low_q    <= bus.s_writedata[23:0];
          3'd2:    high_q   <= bus.s_writedata[23:0];
          3'd3:    hilite_q <= bus.s_writedata[23:0];
          default: ;
        endcase
      end

      // Read uses the pre-write register value, so a same-cycle write returns old data.
      if (bus.s_chipselect && bus.s_read) readdata_q <= rdata;
    end
  end

endmodule

// File: tb/tb_eee_img_proc.sv
// Randomised scoreboard bench for eee_img_proc: a frame-level reference model predicts every
// output pixel and the per-frame statistics; a monitor compares the stream as it emerges.
module tb_eee_img_proc;
  localparam int unsigned W = 64;
  localparam int unsigned H = 48;

  logic clk = 1'b0;
  logic reset;
  logic mode;
  bit   rand_ready;

  eee_img_proc_if bus ();

  eee_img_proc #(.IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        sop;
    logic        eop;
  } pix_t;

  pix_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] m_low, m_high, m_hilite;
  int m_idx, m_count, m_xmin, m_xmax, m_ymin, m_ymax;
  logic [31:0] m_fcount, m_bbmin, m_bbmax, m_frames;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic bit in_box(input logic [23:0] p);
    logic [7:0] c, lo, hi;
    for (int i = 0; i < 3; i++) begin
      c  = p[i*8 +: 8];
      lo = m_low[i*8 +: 8];
      hi = m_high[i*8 +: 8];
      if (c < lo || c > hi) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic acc_clear();
    m_count = 0; m_xmin = 'h7FF; m_xmax = 0; m_ymin = 'h7FF; m_ymax = 0;
  endtask

  task automatic model_reset();
    m_low = 24'hC00000; m_high = 24'hFF4040; m_hilite = 24'h00FF00;
    m_idx = 0;
    acc_clear();
    m_fcount = 0; m_bbmin = 0; m_bbmax = 0; m_frames = 0;
  endtask

  // Position follows from the pixel's index within the frame; rows beyond the last stay on it.
  task automatic model_accept(input logic [23:0] d, input logic sop, input logic eop);
    int x, y;
    bit hit;
    pix_t e;
    if (sop) begin m_idx = 0; acc_clear(); end
    x = m_idx % W;
    y = m_idx / W;
    if (y > H - 1) y = H - 1;
    m_idx++;
    hit = in_box(d);
    if (hit) begin
      m_count++;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
    e.data = (mode && hit) ? m_hilite : d;
    e.sop  = sop;
    e.eop  = eop;
    exp_q.push_back(e);
    if (eop) begin
      m_fcount = m_count;
      m_bbmin  = (32'(m_ymin) << 16) | 32'(m_xmin);
      m_bbmax  = (32'(m_ymax) << 16) | 32'(m_xmax);
      m_frames++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input logic [23:0] d, input logic sop, input logic eop);
    bus.sink_valid = 1'b1;
    bus.sink_data  = d;
    bus.sink_sop   = sop;
    bus.sink_eop   = eop;
  endtask

  task automatic wait_accept();
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (bus.sink_ready) break;
      t++;
      if (t > 1000) begin
        fail_now("accept_timeout");
        bus.sink_valid = 1'b0;
        return;
      end
    end
    model_accept(bus.sink_data, bus.sink_sop, bus.sink_eop);
    tick();
    bus.sink_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] d, input logic sop, input logic eop);
    drive_pixel(d, sop, eop);
    wait_accept();
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.source_valid) && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) fail_now("drain");
  endtask

  task automatic mm(input logic [2:0] a, input logic [31:0] wd, input bit wr, input bit rd,
                    input bit cs = 1'b1);
    bus.s_chipselect = cs;
    bus.s_address    = a;
    bus.s_writedata  = wd;
    bus.s_write      = wr;
    bus.s_read       = rd;
    tick();
    bus.s_chipselect = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_read       = 1'b0;
    if (cs && wr) begin
      case (a)
        3'd1: m_low    = wd[23:0];
        3'd2: m_high   = wd[23:0];
        3'd3: m_hilite = wd[23:0];
        default: ;
      endcase
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    mm(a, 32'h0, 1'b0, 1'b1);
    check(name, bus.s_readdata, exp);
  endtask

  task automatic check_stats(input string tag);
    rd_check({tag, "_bbmin"}, 3'd4, m_bbmin);
    rd_check({tag, "_bbmax"}, 3'd5, m_bbmax);
    rd_check({tag, "_fcount"}, 3'd6, m_fcount);
    rd_check({tag, "_frames"}, 3'd7, m_frames);
  endtask

  task automatic random_frame(input int n);
    for (int i = 0; i < n; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      // Bias some pixels into the default box so matches occur often.
      if ($urandom_range(3) == 0) p = {8'($urandom_range(255, 192)), 8'($urandom_range(64)),
                                       8'($urandom_range(64))};
      send_pixel(p, i == 0, i == n - 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.sink_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_reset();
  endtask

  // Monitor: pops on every transfer, and checks hold behaviour while stalled.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.source_valid) begin
        if (!bus.source_ready) begin
          check("stall_sink_ready", {31'b0, bus.sink_ready}, 32'd0);
          if (exp_q.size() != 0)
            check("stall_hold", {6'b0, bus.source_sop, bus.source_eop, bus.source_data},
                  {6'b0, exp_q[0].sop, exp_q[0].eop, exp_q[0].data});
        end else if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          check("out_pixel", {6'b0, bus.source_sop, bus.source_eop, bus.source_data},
                {6'b0, e.sop, e.eop, e.data});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.source_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_chipselect = 1'b0; bus.s_read = 1'b0; bus.s_write = 1'b0;
    bus.s_address = '0; bus.s_writedata = '0;
    bus.sink_data = '0; bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
    bus.source_ready = 1'b1;
    mode = 1'b0;
    rand_ready = 1'b0;
    reset = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", {31'b0, bus.source_valid}, 32'd0);
    check("rst_data", {8'b0, bus.source_data}, 32'd0);
    check("rst_sop_eop", {30'b0, bus.source_sop, bus.source_eop}, 32'd0);
    check("rst_readdata", bus.s_readdata, 32'd0);
    check("rst_sink_ready", {31'b0, bus.sink_ready}, 32'd1);
    rd_check("rst_id", 3'd0, 32'h1234EEE0);
    rd_check("rst_low", 3'd1, 32'h00C00000);
    rd_check("rst_high", 3'd2, 32'h00FF4040);
    rd_check("rst_hilite", 3'd3, 32'h0000FF00);
    check_stats("rst");

    // Pass-through with continuous valid/ready
    mode = 1'b0;
    random_frame(200);
    drain();
    check_stats("passthru");

    // Highlight mode, directed pixels including box edges
    mode = 1'b1;
    send_pixel(24'hE02010, 1'b1, 1'b0);
    send_pixel(24'h205060, 1'b0, 1'b0);
    send_pixel(24'hC00000, 1'b0, 1'b0);
    send_pixel(24'hFF4040, 1'b0, 1'b0);
    send_pixel(24'hBFFFFF, 1'b0, 1'b0);
    send_pixel(24'hFF4041, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) send_pixel(24'($urandom), 1'b0, i == 49);
    drain();
    check_stats("hilite");

    // Stall for five cycles with a pixel waiting upstream
    bus.source_ready = 1'b0;
    send_pixel(24'hE02010, 1'b1, 1'b0);
    drive_pixel(24'h123456, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("stall_valid", {31'b0, bus.source_valid}, 32'd1);
    tick();
    bus.source_ready = 1'b1;
    wait_accept();
    send_pixel(24'hFF0000, 1'b0, 1'b1);
    drain();

    // Random backpressure over two frames
    rand_ready = 1'b1;
    mode = 1'b0;
    random_frame(300);
    mode = 1'b1;
    random_frame(300);
    rand_ready = 1'b0;
    bus.source_ready = 1'b1;
    drain();
    check_stats("backpressure");

    // Full frame with two matches at (10,20) and (40,30)
    mode = 1'b0;
    for (int i = 0; i < int'(W * H); i++) begin
      logic [23:0] p;
      p = (i == 20 * W + 10 || i == 30 * W + 40) ? 24'hE02010 : 24'h000000;
      send_pixel(p, i == 0, i == int'(W * H) - 1);
    end
    drain();
    rd_check("full_fcount", 3'd6, 32'd2);
    rd_check("full_bbmin", 3'd4, 32'h0014000A);
    rd_check("full_bbmax", 3'd5, 32'h001E0028);
    check_stats("full");

    // Overlong frame: rows past the last one stay clamped to it
    for (int i = 0; i < int'(W * H) + 70; i++) begin
      logic [23:0] p;
      p = (i == 5 || i == int'(W * H) + 50) ? 24'hC01020 : 24'h000000;
      send_pixel(p, i == 0, i == int'(W * H) + 69);
    end
    drain();
    rd_check("sat_bbmax", 3'd5, 32'h002F0032);
    check_stats("sat");

    // Zero-match frame, then a one-pixel frame
    for (int i = 0; i < 10; i++) send_pixel(24'h000000, i == 0, i == 9);
    drain();
    rd_check("zero_bbmin", 3'd4, 32'h07FF07FF);
    rd_check("zero_bbmax", 3'd5, 32'h00000000);
    rd_check("zero_fcount", 3'd6, 32'd0);
    send_pixel(24'hE02010, 1'b1, 1'b1);
    drain();
    rd_check("one_fcount", 3'd6, 32'd1);
    rd_check("one_bbmin", 3'd4, 32'h00000000);
    check_stats("one");

    // Register access
    mm(3'd1, 32'hFF123456, 1'b1, 1'b0);
    rd_check("low_mask", 3'd1, 32'h00123456);
    mm(3'd6, 32'hDEADBEEF, 1'b1, 1'b0);
    rd_check("ro_fcount", 3'd6, m_fcount);
    mm(3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    mode = 1'b1;
    rd_check("id_mode1", 3'd0, 32'h1234EEE1);
    mode = 1'b0;
    rd_check("id_mode0", 3'd0, 32'h1234EEE0);
    mm(3'd2, 32'h000000AB, 1'b1, 1'b1);
    check("rw_same_old", bus.s_readdata, 32'h00FF4040);
    rd_check("rw_same_new", 3'd2, 32'h000000AB);
    mm(3'd3, 32'h00ABCDEF, 1'b1, 1'b0);
    check("readdata_hold", bus.s_readdata, 32'h000000AB);
    mm(3'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    check("read_no_cs", bus.s_readdata, 32'h000000AB);
    rd_check("hilite_rd", 3'd3, 32'h00ABCDEF);

    // Custom box and highlight colour
    mm(3'd1, 32'h00404040, 1'b1, 1'b0);
    mm(3'd2, 32'h00C0C0C0, 1'b1, 1'b0);
    mm(3'd3, {8'h0, 24'($urandom)}, 1'b1, 1'b0);
    mode = 1'b1;
    random_frame(100);
    drain();
    check_stats("custom");

    // Reset while a pixel is held and another waits upstream
    bus.source_ready = 1'b0;
    send_pixel(24'h808080, 1'b1, 1'b0);
    drive_pixel(24'h818181, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    bus.sink_valid = 1'b0;
    tick();
    check("midrst_valid", {31'b0, bus.source_valid}, 32'd0);
    check("midrst_data", {8'b0, bus.source_data}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    bus.source_ready = 1'b1;
    rd_check("midrst_low", 3'd1, 32'h00C00000);
    check_stats("midrst");
    random_frame(20);
    drain();
    check_stats("after_rst");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
